// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the memory request controller:
//                the controller state encoding and the default address,
//                data and burst-length field widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;
    localparam int LW_DEF = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_RESP  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_ctrl
//  Description : Single-request memory controller. Accepts one write or one
//                read burst at a time, drives a simple synchronous memory
//                port, and returns read beats over a valid/ready response
//                channel. All outputs come straight from flops.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst_n              clock (rising edge), async active-low reset
//    req_valid/req_ready     request handshake (ready only when idle)
//    req_write               1 = write, 0 = read
//    req_addr, req_len       start address, read beats minus one
//    req_wdata               write data
//    rsp_valid/rsp_ready     read response handshake
//    rsp_data, rsp_last      read beat data, final-beat marker
//    busy                    controller not idle
//    mem_w, mem_addr         memory write enable, memory address
//    mem_data_i              data driven into memory (write data)
//    mem_data_o              data returned by memory (read data)
// ============================================================================
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int LW     = LW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [LW-1:0] req_len,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic          busy,
    output logic          mem_w,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_i,
    input  logic [DW-1:0] mem_data_o
);

    // Beat counter holds req_len+1, so it needs one bit more than req_len
    // to represent a full 2^LW-beat burst.
    localparam int CW  = LW + 1;
    // Wait counter counts down from RD_LAT-1 to 0.
    localparam int WTW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WTW-1:0]  wait_q, wait_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            mem_w_q, mem_w_d;
    logic            req_ready_q, req_ready_d;
    logic            busy_q, busy_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_last_q, rsp_last_d;

    // ------------------------------------------------------------------
    // State register and all output flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            wait_q      <= '0;
            rdata_q     <= '0;
            mem_w_q     <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            rdata_q     <= rdata_d;
            mem_w_q     <= mem_w_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d = req_addr;
                    if (req_write) begin
                        state_d = WRITE;
                        wdata_d = req_wdata;
                    end else begin
                        state_d = RD_ISSUE;
                        cnt_d   = CW'(req_len) + CW'(1);
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
                wait_d  = WTW'(RD_LAT - 1);
            end
            RD_WAIT: begin
                if (wait_q == '0) begin
                    state_d = RD_RESP;
                    rdata_d = mem_data_o;
                end else begin
                    wait_d = wait_q - WTW'(1);
                end
            end
            RD_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q > CW'(1)) begin
                        // Address wraps naturally at 2^AW.
                        addr_d  = addr_q + AW'(1);
                        state_d = RD_ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so that they appear on
        // flops in the same cycle the state takes effect.
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        mem_w_d     = (state_d == WRITE);
        rsp_valid_d = (state_d == RD_RESP);
        rsp_last_d  = (state_d == RD_RESP) && (cnt_d == CW'(1));
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign mem_w      = mem_w_q;
    assign mem_addr   = addr_q;
    assign mem_data_i = wdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rdata_q;
    assign rsp_last   = rsp_last_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_req_ctrl
//  Description : Directed testbench for mem_req_ctrl. A RD_LAT=1 instance
//                is the main target; a RD_LAT=2 instance shares the request
//                inputs and is examined only for response latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, rsp_ready;
    logic [7:0]  req_addr;
    logic [3:0]  req_len;
    logic [31:0] req_wdata;

    logic        req_ready, rsp_valid, rsp_last, busy, mem_w;
    logic [31:0] rsp_data, mem_data_i, mem_data_o;
    logic [7:0]  mem_addr;

    logic        req_ready2, rsp_valid2, rsp_last2, busy2, mem_w2;
    logic [31:0] rsp_data2, mem_data_i2, mem_data_o2;
    logic [7:0]  mem_addr2;

    logic        mem_init;
    logic [31:0] mem [0:255];
    logic [31:0] rd1, rd2a, rd2b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_req_ctrl #(.AW(8), .DW(32), .LW(4), .RD_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy), .mem_w(mem_w), .mem_addr(mem_addr),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o)
    );

    mem_req_ctrl #(.AW(8), .DW(32), .LW(4), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready2), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2),
        .rsp_last(rsp_last2), .busy(busy2), .mem_w(mem_w2), .mem_addr(mem_addr2),
        .mem_data_i(mem_data_i2), .mem_data_o(mem_data_o2)
    );

    // Memory model: contents preset to 0xC0DE0000+addr, written by the main
    // instance only; read pipelines of depth 1 and 2 for the two instances.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 + i;
        end else if (mem_w) begin
            mem[mem_addr] <= mem_data_i;
        end
        rd1  <= mem[mem_addr];
        rd2a <= mem[mem_addr2];
        rd2b <= rd2a;
    end
    assign mem_data_o  = rd1;
    assign mem_data_o2 = rd2b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge (controller assumed idle).
    task automatic issue(input logic wr, input logic [7:0] a, input logic [3:0] l,
                         input logic [31:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_len   = l;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 12 && rsp_valid !== 1'b1; k++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_init = 1'b1;
        repeat (3) tick();
        mem_init = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if ({rsp_valid, rsp_last, mem_w} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {rsp_valid, rsp_last, mem_w}); end
        n_cmp++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        n_cmp++; if (mem_addr !== 8'h0 || mem_data_i !== 32'h0) begin n_fail++; $display("FAIL rst_mem_bus: got %h/%h want 0/0", mem_addr, mem_data_i); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle();
        req_valid = 1'b0;
        req_write = 1'b1;
        req_addr  = 8'h33;
        req_wdata = 32'h1234;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (busy !== 1'b0 || mem_w !== 1'b0) begin n_fail++; $display("FAIL idle_quiet: busy/mem_w got %b%b want 00", busy, mem_w); end
        end
    endtask

    task automatic test_write();
        issue(1'b1, 8'd5, 4'd0, 32'd4);
        n_cmp++; if (mem_w !== 1'b1) begin n_fail++; $display("FAIL wr_mem_w: got %b want 1", mem_w); end
        n_cmp++; if (mem_addr !== 8'd5 || mem_data_i !== 32'd4) begin n_fail++; $display("FAIL wr_bus: got %h/%h want 05/4", mem_addr, mem_data_i); end
        n_cmp++; if (req_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wr_ready_busy: got %b%b want 01", req_ready, busy); end
        tick();
        n_cmp++; if (mem_w !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_end: mem_w/ready/busy got %b%b%b want 010", mem_w, req_ready, busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp: got %b want 0", rsp_valid); end
    endtask

    task automatic test_read_single();
        rsp_ready = 1'b1;
        issue(1'b0, 8'd5, 4'd0, 32'd0);
        n_cmp++; if (mem_addr !== 8'd5 || mem_w !== 1'b0) begin n_fail++; $display("FAIL rd1_issue: addr/mem_w got %h/%b want 05/0", mem_addr, mem_w); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd1_wait: rsp_valid got %b want 0", rsp_valid); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_last !== 1'b1) begin n_fail++; $display("FAIL rd1_resp: valid/last got %b%b want 11", rsp_valid, rsp_last); end
        n_cmp++; if (rsp_data !== 32'd4) begin n_fail++; $display("FAIL rd1_data: got %h want 4", rsp_data); end
        tick();
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rd1_done: busy/valid/ready got %b%b%b want 001", busy, rsp_valid, req_ready); end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] ea;
        rsp_ready = 1'b1;
        issue(1'b0, 8'd254, 4'd3, 32'd0);
        for (int b = 0; b < 4; b++) begin
            ea = 8'(254 + b);
            wait_valid();
            n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL burst_timeout: beat %0d valid got %b want 1", b, rsp_valid); end
            n_cmp++; if (rsp_data !== (32'hC0DE_0000 + 32'(ea))) begin n_fail++; $display("FAIL burst_data: beat %0d got %h want %h", b, rsp_data, 32'hC0DE_0000 + 32'(ea)); end
            n_cmp++; if (mem_addr !== ea) begin n_fail++; $display("FAIL burst_addr: beat %0d got %h want %h", b, mem_addr, ea); end
            n_cmp++; if (rsp_last !== (b == 3)) begin n_fail++; $display("FAIL burst_last: beat %0d got %b want %b", b, rsp_last, (b == 3)); end
            n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL burst_overlap: beat %0d req_ready got %b want 0", b, req_ready); end
            tick();
        end
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL burst_done: busy/valid got %b%b want 00", busy, rsp_valid); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        issue(1'b0, 8'd10, 4'd1, 32'd0);
        wait_valid();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hC0DE_000A || rsp_last !== 1'b0) begin n_fail++; $display("FAIL bp_first: valid/data/last got %b/%h/%b want 1/c0de000a/0", rsp_valid, rsp_data, rsp_last); end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hC0DE_000A || mem_addr !== 8'd10) begin n_fail++; $display("FAIL bp_hold: cycle %0d valid/data/addr got %b/%h/%h want 1/c0de000a/0a", k, rsp_valid, rsp_data, mem_addr); end
        end
        rsp_ready = 1'b1;
        tick();
        n_cmp++; if (rsp_valid !== 1'b0 || mem_addr !== 8'd11) begin n_fail++; $display("FAIL bp_advance: valid/addr got %b/%h want 0/0b", rsp_valid, mem_addr); end
        wait_valid();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hC0DE_000B || rsp_last !== 1'b1) begin n_fail++; $display("FAIL bp_second: valid/data/last got %b/%h/%b want 1/c0de000b/1", rsp_valid, rsp_data, rsp_last); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_done: busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int seen;
        rsp_ready = 1'b1;
        issue(1'b0, 8'd20, 4'd3, 32'd0);
        wait_valid();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_timeout: valid got %b want 1", rsp_valid); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if ({rsp_valid, rsp_last, busy, mem_w, req_ready} !== 5'b00001) begin n_fail++; $display("FAIL mid_flags: valid/last/busy/mem_w/ready got %b want 00001", {rsp_valid, rsp_last, busy, mem_w, req_ready}); end
        n_cmp++; if (rsp_data !== 32'h0 || mem_addr !== 8'h0) begin n_fail++; $display("FAIL mid_data: data/addr got %h/%h want 0/0", rsp_data, mem_addr); end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rsp_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_rsp: valid cycles got %0d want 0", seen); end

        issue(1'b1, 8'd30, 4'd0, 32'd77);
        n_cmp++; if (mem_w !== 1'b1) begin n_fail++; $display("FAIL wrst_pre: mem_w got %b want 1", mem_w); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_w !== 1'b0 || mem_data_i !== 32'h0) begin n_fail++; $display("FAIL wrst_now: mem_w/wdata got %b/%h want 0/0", mem_w, mem_data_i); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (mem[30] !== 32'hC0DE_001E) begin n_fail++; $display("FAIL wrst_mem: mem[30] got %h want c0de001e", mem[30]); end
    endtask

    task automatic test_lat2();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rsp_ready = 1'b1;
        issue(1'b0, 8'd5, 4'd0, 32'd0);   // handshake edge E0
        n_cmp++; if (rsp_valid2 !== 1'b0 || busy2 !== 1'b1) begin n_fail++; $display("FAIL lat2_e0: valid/busy got %b%b want 01", rsp_valid2, busy2); end
        tick();                           // E1
        n_cmp++; if (rsp_valid2 !== 1'b0) begin n_fail++; $display("FAIL lat2_e1: valid got %b want 0", rsp_valid2); end
        tick();                           // E2
        n_cmp++; if (rsp_valid2 !== 1'b0) begin n_fail++; $display("FAIL lat2_e2: valid got %b want 0", rsp_valid2); end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd4) begin n_fail++; $display("FAIL lat1_e2: valid/data got %b/%h want 1/4", rsp_valid, rsp_data); end
        tick();                           // E3: fourth cycle after handshake cycle
        n_cmp++; if (rsp_valid2 !== 1'b1 || rsp_data2 !== 32'd4 || rsp_last2 !== 1'b1) begin n_fail++; $display("FAIL lat2_e3: valid/data/last got %b/%h/%b want 1/4/1", rsp_valid2, rsp_data2, rsp_last2); end
        tick();
        n_cmp++; if (busy2 !== 1'b0 || req_ready2 !== 1'b1) begin n_fail++; $display("FAIL lat2_done: busy/ready got %b%b want 01", busy2, req_ready2); end
    endtask

    initial begin
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_idle();
        test_write();
        test_read_single();
        test_burst_wrap();
        test_backpressure();
        test_reset_mid();
        test_lat2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
`default_nettype wire
